// File: rtl/lab4_sweep_ctrl_if.sv
// ---------------------------------------------------------------------------
// lab4_sweep_ctrl_if
//
// Purpose: bundles the control, stimulus and result signals that pass
// between the sweep sequencer and its host / function unit.
//
// Signals:
//   start      host -> ctrl   begin a sweep (sampled in IDLE only)
//   abort      host -> ctrl   cancel a sweep in progress
//   g_in       unit -> ctrl   G output of the function unit
//   vec        ctrl -> unit   {A,B,C,D} drive to the function unit
//   busy       ctrl -> host   sweep in progress
//   done       ctrl -> host   one-cycle pulse on sweep completion
//   pass       ctrl -> host   last completed sweep had zero mismatches
//   err_cnt    ctrl -> host   mismatch count (0..16)
//   result     ctrl -> host   captured G map, bit n = G for vec n
//   first_fail ctrl -> host   vec value of the first mismatch
//   fail_valid ctrl -> host   first_fail is meaningful
//
// Modports: master = host/function-unit side, slave = sweep controller.
// ---------------------------------------------------------------------------
interface lab4_sweep_ctrl_if;
   logic        start;
   logic        abort;
   logic        g_in;
   logic [3:0]  vec;
   logic        busy;
   logic        done;
   logic        pass;
   logic [4:0]  err_cnt;
   logic [15:0] result;
   logic [3:0]  first_fail;
   logic        fail_valid;

   modport master (
      output start, abort, g_in,
      input  vec, busy, done, pass, err_cnt, result, first_fail, fail_valid
   );

   modport slave (
      input  start, abort, g_in,
      output vec, busy, done, pass, err_cnt, result, first_fail, fail_valid
   );
endinterface

// File: rtl/lab4_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// lab4_sweep_ctrl
//
// Purpose: exhaustive-sweep sequencer for the 4-input SOP function unit.
// On an accepted start it presents all 16 {A,B,C,D} vectors (binary or
// reflected Gray order), holds each for SETTLE_CYC+1 cycles, captures G on
// the last cycle of each vector and compares it against the EXPECT table.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   sweep  lab4_sweep_ctrl_if.slave (start/abort/g_in in, results out)
//
// Parameters:
//   SETTLE_CYC  extra hold cycles per vector before capture (0..255)
//   GRAY        0 = binary order, 1 = reflected Gray order
//   EXPECT      golden table, bit n = expected G for vec n (A is MSB)
// ---------------------------------------------------------------------------
module lab4_sweep_ctrl #(
   parameter int unsigned SETTLE_CYC = 2,
   parameter bit          GRAY       = 1'b0,
   parameter logic [15:0] EXPECT     = 16'hAD55
) (
   input  logic              clk,
   input  logic              rst_n,
   lab4_sweep_ctrl_if.slave  sweep
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [7:0] SETTLE = 8'(SETTLE_CYC);

   state_t      state_q, state_d;
   logic [3:0]  step_q, step_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [3:0]  vec_q, vec_d;
   logic        pass_q, pass_d;
   logic [4:0]  err_q, err_d;
   logic [15:0] result_q, result_d;
   logic [3:0]  ff_q, ff_d;
   logic        fv_q, fv_d;

   logic startAcc;
   logic capture;
   logic lastStep;

   // Map a step index to the vector actually presented; result and EXPECT
   // are always indexed by this vector value, never by the step index.
   function automatic logic [3:0] order(input logic [3:0] k);
      return GRAY ? (k ^ (k >> 1)) : k;
   endfunction

   // abort beats start in IDLE, and beats a same-cycle capture in RUN.
   assign startAcc = (state_q == IDLE) && sweep.start && !sweep.abort;
   assign capture  = (state_q == RUN) && !sweep.abort && (cnt_q == 8'd0);
   assign lastStep = (step_q == 4'd15);

   // State register plus all datapath registers; everything clears on
   // reset so an interrupted sweep leaves no stale results behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         step_q   <= 4'd0;
         cnt_q    <= 8'd0;
         vec_q    <= 4'd0;
         pass_q   <= 1'b0;
         err_q    <= 5'd0;
         result_q <= 16'd0;
         ff_q     <= 4'd0;
         fv_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         step_q   <= step_d;
         cnt_q    <= cnt_d;
         vec_q    <= vec_d;
         pass_q   <= pass_d;
         err_q    <= err_d;
         result_q <= result_d;
         ff_q     <= ff_d;
         fv_q     <= fv_d;
      end
   end

   // Next-state logic: DONE is a single-cycle state that always returns
   // to IDLE, so start is only ever honoured from IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (startAcc) state_d = RUN;
         RUN: begin
            if (sweep.abort)
               state_d = IDLE;
            else if (capture && lastStep)
               state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath next-state: settle counting, capture/compare, and stepping
   // through the vector order. pass is computed on the final capture edge
   // so it is already valid in the DONE cycle and then simply holds.
   always_comb begin
      step_d   = step_q;
      cnt_d    = cnt_q;
      vec_d    = vec_q;
      pass_d   = pass_q;
      err_d    = err_q;
      result_d = result_q;
      ff_d     = ff_q;
      fv_d     = fv_q;
      case (state_q)
         IDLE: begin
            if (startAcc) begin
               step_d   = 4'd0;
               cnt_d    = SETTLE;
               vec_d    = order(4'd0);
               pass_d   = 1'b0;
               err_d    = 5'd0;
               result_d = 16'd0;
               fv_d     = 1'b0;
            end
         end
         RUN: begin
            if (sweep.abort) begin
               vec_d  = 4'd0;
               pass_d = 1'b0;
            end else if (cnt_q != 8'd0) begin
               cnt_d = cnt_q - 8'd1;
            end else begin
               result_d[vec_q] = sweep.g_in;
               if (sweep.g_in != EXPECT[vec_q]) begin
                  err_d = err_q + 5'd1;
                  if (!fv_q) begin
                     ff_d = vec_q;
                     fv_d = 1'b1;
                  end
               end
               if (!lastStep) begin
                  step_d = step_q + 4'd1;
                  vec_d  = order(step_q + 4'd1);
                  cnt_d  = SETTLE;
               end else begin
                  vec_d  = 4'd0;
                  pass_d = (err_d == 5'd0);
               end
            end
         end
         default: vec_d = 4'd0;
      endcase
   end

   // Outputs: busy and done are decodes of the registered state, the rest
   // come straight from registers, so no input reaches an output
   // combinationally.
   always_comb begin
      sweep.busy       = (state_q == RUN);
      sweep.done       = (state_q == DONE);
      sweep.vec        = vec_q;
      sweep.pass       = pass_q;
      sweep.err_cnt    = err_q;
      sweep.result     = result_q;
      sweep.first_fail = ff_q;
      sweep.fail_valid = fv_q;
   end

endmodule

// File: tb/tb_lab4_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lab4_sweep_ctrl
//
// Purpose: directed bench for lab4_sweep_ctrl. dutA sweeps in binary
// order, dutB in Gray order; both use SETTLE_CYC=2 and the default table.
// A behavioural model of the SOP function unit (with selectable faults)
// drives g_in. Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_lab4_sweep_ctrl;

   logic clk;
   logic rst_n;
   int   faultMode;
   int   total;
   int   bad;
   int   busyCycles;
   int   vecErrs;
   int   waitCyc;
   logic [3:0] grayTab [16];

   lab4_sweep_ctrl_if ifA ();
   lab4_sweep_ctrl_if ifB ();

   lab4_sweep_ctrl #(.SETTLE_CYC(2), .GRAY(1'b0), .EXPECT(16'hAD55)) dutA (
      .clk   (clk),
      .rst_n (rst_n),
      .sweep (ifA.slave)
   );

   lab4_sweep_ctrl #(.SETTLE_CYC(2), .GRAY(1'b1), .EXPECT(16'hAD55)) dutB (
      .clk   (clk),
      .rst_n (rst_n),
      .sweep (ifB.slave)
   );

   // Free-running 10-time-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Function unit G = A'D' + ABD + B'D' + ACD. Mode 1 = stuck at 0,
   // mode 2 = output inverted only for vec 11.
   function automatic logic fu(input logic [3:0] v, input int mode);
      logic a, b, c, d, g;
      {a, b, c, d} = v;
      g = (!a && !d) || (a && b && d) || (!b && !d) || (a && c && d);
      if (mode == 1)
         g = 1'b0;
      else if (mode == 2 && v == 4'd11)
         g = !g;
      return g;
   endfunction

   assign ifA.g_in = fu(ifA.vec, faultMode);
   assign ifB.g_in = fu(ifB.vec, faultMode);

   // Compare one observed value against its hand-derived expectation.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drive start/abort on one DUT, then advance the given number of
   // falling edges.
   task automatic applyStimulus(input bit useB, input bit s, input bit a,
                                input int cycles);
      if (useB) begin
         ifB.start = s;
         ifB.abort = a;
      end else begin
         ifA.start = s;
         ifA.abort = a;
      end
      for (int i = 0; i < cycles; i++) @(negedge clk);
   endtask

   // One-cycle start pulse; returns on the first cycle after the start edge.
   task automatic pulseStart(input bit useB);
      applyStimulus(useB, 1'b1, 1'b0, 1);
      applyStimulus(useB, 1'b0, 1'b0, 0);
   endtask

   // Follow a sweep while busy, counting busy cycles and vec-order misses.
   // Optionally re-asserts start for one cycle at busy cycle restartAt.
   task automatic observeSweep(input bit useB, input int restartAt,
                               output int nBusy, output int nVecErr);
      logic [3:0] expV;
      logic [3:0] curVec;
      nBusy   = 0;
      nVecErr = 0;
      while ((useB ? ifB.busy : ifA.busy) === 1'b1 && nBusy < 200) begin
         curVec = useB ? ifB.vec : ifA.vec;
         if (nBusy < 48) begin
            expV = useB ? grayTab[nBusy / 3] : 4'(nBusy / 3);
            if (curVec !== expV) nVecErr++;
         end else begin
            nVecErr++;
         end
         nBusy++;
         applyStimulus(useB, (nBusy - 1) == restartAt, 1'b0, 1);
      end
   endtask

   // Checks made on the done cycle and the cycle after it.
   task automatic checkSweepEnd(input string name, input bit useB,
                                input int nBusy, input int nVecErr,
                                input logic [15:0] expResult,
                                input logic [4:0] expErr,
                                input logic [3:0] expFf, input bit expFv,
                                input bit expPass);
      checkOutput({name, ".busyCycles"}, nBusy, 48);
      checkOutput({name, ".vecOrder"}, nVecErr, 0);
      checkOutput({name, ".done"}, useB ? ifB.done : ifA.done, 1);
      checkOutput({name, ".vecAtDone"}, useB ? ifB.vec : ifA.vec, 0);
      checkOutput({name, ".pass"}, useB ? ifB.pass : ifA.pass, expPass);
      checkOutput({name, ".result"}, useB ? ifB.result : ifA.result, expResult);
      checkOutput({name, ".errCnt"}, useB ? ifB.err_cnt : ifA.err_cnt, expErr);
      checkOutput({name, ".failValid"}, useB ? ifB.fail_valid : ifA.fail_valid, expFv);
      if (expFv)
         checkOutput({name, ".firstFail"}, useB ? ifB.first_fail : ifA.first_fail, expFf);
      applyStimulus(useB, 1'b0, 1'b0, 1);
      checkOutput({name, ".doneDrop"}, useB ? ifB.done : ifA.done, 0);
      checkOutput({name, ".passHold"}, useB ? ifB.pass : ifA.pass, expPass);
   endtask

   // Directed scenario sequence.
   initial begin
      total     = 0;
      bad       = 0;
      faultMode = 0;
      grayTab   = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                    4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
      rst_n     = 1'b0;
      ifA.start = 1'b0;
      ifA.abort = 1'b0;
      ifB.start = 1'b0;
      ifB.abort = 1'b0;
      #12;
      checkOutput("reset.vecA", ifA.vec, 0);
      checkOutput("reset.busyA", ifA.busy, 0);
      checkOutput("reset.doneA", ifA.done, 0);
      checkOutput("reset.passA", ifA.pass, 0);
      checkOutput("reset.resultA", ifA.result, 0);
      checkOutput("reset.errA", ifA.err_cnt, 0);
      checkOutput("reset.fvA", ifA.fail_valid, 0);
      checkOutput("reset.busyB", ifB.busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] clean binary sweep with mid-sweep start");
      pulseStart(1'b0);
      observeSweep(1'b0, 20, busyCycles, vecErrs);
      checkSweepEnd("cleanA", 1'b0, busyCycles, vecErrs, 16'hAD55, 5'd0, 4'd0, 1'b0, 1'b1);

      $display("[TB] g_in stuck at 0");
      faultMode = 1;
      pulseStart(1'b0);
      observeSweep(1'b0, -1, busyCycles, vecErrs);
      checkSweepEnd("stuck0", 1'b0, busyCycles, vecErrs, 16'h0000, 5'd9, 4'd0, 1'b1, 1'b0);

      $display("[TB] g_in inverted at vec 11");
      faultMode = 2;
      pulseStart(1'b0);
      observeSweep(1'b0, -1, busyCycles, vecErrs);
      checkSweepEnd("inv11", 1'b0, busyCycles, vecErrs, 16'hA555, 5'd1, 4'd11, 1'b1, 1'b0);

      $display("[TB] Gray sweep then back-to-back start");
      faultMode = 0;
      pulseStart(1'b1);
      observeSweep(1'b1, -1, busyCycles, vecErrs);
      checkSweepEnd("grayB", 1'b1, busyCycles, vecErrs, 16'hAD55, 5'd0, 4'd0, 1'b0, 1'b1);
      pulseStart(1'b1);
      observeSweep(1'b1, -1, busyCycles, vecErrs);
      checkSweepEnd("grayB2b", 1'b1, busyCycles, vecErrs, 16'hAD55, 5'd0, 4'd0, 1'b0, 1'b1);

      $display("[TB] abort while vec=5");
      pulseStart(1'b0);
      waitCyc = 0;
      while (ifA.vec !== 4'd5 && waitCyc < 100) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1);
         waitCyc++;
      end
      checkOutput("abort5.reach", waitCyc < 100, 1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 0);
      checkOutput("abort5.busy", ifA.busy, 0);
      checkOutput("abort5.vec", ifA.vec, 0);
      checkOutput("abort5.done", ifA.done, 0);
      checkOutput("abort5.pass", ifA.pass, 0);
      checkOutput("abort5.result", ifA.result, 16'h0015);
      checkOutput("abort5.err", ifA.err_cnt, 0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1);
      checkOutput("abort5.noDone", ifA.done, 0);

      $display("[TB] clean sweep after abort");
      pulseStart(1'b0);
      observeSweep(1'b0, -1, busyCycles, vecErrs);
      checkSweepEnd("afterAbort", 1'b0, busyCycles, vecErrs, 16'hAD55, 5'd0, 4'd0, 1'b0, 1'b1);

      $display("[TB] abort on the capture cycle of vec 4");
      faultMode = 1;
      pulseStart(1'b0);
      waitCyc = 0;
      while (ifA.vec !== 4'd4 && waitCyc < 100) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1);
         waitCyc++;
      end
      checkOutput("abortCap.reach", waitCyc < 100, 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 2);
      applyStimulus(1'b0, 1'b0, 1'b1, 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 0);
      checkOutput("abortCap.busy", ifA.busy, 0);
      checkOutput("abortCap.err", ifA.err_cnt, 2);
      checkOutput("abortCap.ff", ifA.first_fail, 0);
      checkOutput("abortCap.fv", ifA.fail_valid, 1);
      checkOutput("abortCap.result", ifA.result, 16'h0000);

      $display("[TB] reset in the middle of a sweep");
      faultMode = 0;
      pulseStart(1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 20);
      rst_n = 1'b0;
      #1;
      checkOutput("midRst.vec", ifA.vec, 0);
      checkOutput("midRst.busy", ifA.busy, 0);
      checkOutput("midRst.result", ifA.result, 0);
      checkOutput("midRst.err", ifA.err_cnt, 0);
      checkOutput("midRst.fv", ifA.fail_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      pulseStart(1'b0);
      observeSweep(1'b0, -1, busyCycles, vecErrs);
      checkSweepEnd("afterRst", 1'b0, busyCycles, vecErrs, 16'hAD55, 5'd0, 4'd0, 1'b0, 1'b1);

      $display("[TB] start and abort together in IDLE");
      applyStimulus(1'b0, 1'b1, 1'b1, 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 0);
      checkOutput("startAbort.busy", ifA.busy, 0);
      checkOutput("startAbort.passHold", ifA.pass, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lab4_sweep_ctrl.md
# lab4_sweep_ctrl

Exhaustive-sweep sequencer for the team's 4-input sum-of-products function unit (G = A'D' + ABD + B'D' + ACD). On a start pulse it drives all 16 {A,B,C,D} combinations into the unit, in binary or Gray order. It holds each vector for a programmable settle time, captures G, and compares it against a golden truth table. It replaces hand-written delay testbenches with a synthesizable on-chip self-check that sits beside the function unit.

## Interface
Parameters:
- SETTLE_CYC, 2, extra cycles each vector is held before G is captured (0..255).
- GRAY, 0, 0 = binary vector order, 1 = reflected Gray order.
- EXPECT, 16'hAD55, golden truth table; bit n = expected G for {A,B,C,D} = n, with A as MSB.

Ports (clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin sweep (sampled in IDLE only)
- abort  in  1  cancel sweep in progress
- g_in  in  1  G output of function unit (combinational, same clock domain)
- vec  out  4  {A,B,C,D} drive to function unit
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse on sweep completion
- pass  out  1  last completed sweep had zero mismatches
- err_cnt  out  5  mismatch count (0..16)
- result  out  16  captured G map, bit n = G for vec n
- first_fail  out  4  vec value of first mismatch
- fail_valid  out  1  first_fail is meaningful

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - vec = 0.
  - start=1 and abort=0 → RUN. On entry: step k = 0, settle counter = SETTLE_CYC, result = 0, err_cnt = 0, fail_valid = 0, pass = 0, vec = order(0).
- Vector order:
  - order(k) = k when GRAY=0.
  - order(k) = k ^ (k>>1) when GRAY=1.
  - result and EXPECT are always indexed by vec value, never by step.
- RUN:
  - Counter decrements each cycle while nonzero.
  - On the edge where counter == 0:
    - capture result[vec] = g_in.
    - If g_in != EXPECT[vec]: err_cnt += 1; if fail_valid = 0, set first_fail = vec and fail_valid = 1.
  - Then, if k < 15: k += 1, vec = order(k), counter = SETTLE_CYC. Otherwise go to DONE.
- DONE: lasts one cycle. done = 1, busy = 0, pass = (err_cnt == 0), vec = 0. Then IDLE.
- abort=1 in RUN → IDLE on the next edge.
  - abort has priority over a same-cycle capture; that capture is discarded.
  - No done pulse; pass = 0; result, err_cnt, first_fail and fail_valid keep their partial values.
- start=1 while in RUN or DONE: ignored.
- start and abort both high in IDLE: abort wins, stay in IDLE.
- err_cnt saturates naturally at 16; no wrap is possible.
- pass, err_cnt, result, first_fail and fail_valid hold until the next accepted start.

## Timing
- Reset (asynchronous, any state, including mid-sweep): state = IDLE; vec, busy, done, pass, err_cnt, result, first_fail and fail_valid all = 0.
- Start is accepted at edge E0. From the cycle after E0: busy = 1 and vec = order(0).
- Each vector is presented for exactly SETTLE_CYC+1 cycles.
- Capture k occurs at edge E0 + (SETTLE_CYC+1)·(k+1).
- The done pulse occupies the cycle after capture 15; busy is 1 for exactly 16·(SETTLE_CYC+1) cycles.
- SETTLE_CYC = 0: a new vector every cycle; g_in is sampled in the same cycle vec is presented. This requires the function unit to meet a single-cycle combinational path.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Back-to-back: a start in the first IDLE cycle after DONE is accepted.

## Test plan
- Correct function unit, SETTLE_CYC=2, GRAY=0, start pulse → busy high 48 cycles, vec 0..15 each held 3 cycles, done at cycle 49; result=16'hAD55, err_cnt=0, pass=1, fail_valid=0.
- g_in stuck at 0 → result=16'h0000, err_cnt=9, first_fail=0, fail_valid=1, pass=0.
- GRAY=1, correct unit → vec sequence 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8; result=16'hAD55, pass=1.
- g_in inverted only when vec=11, GRAY=0 → result=16'hA555, err_cnt=1, first_fail=11, pass=0.
- abort asserted while vec=5 → next cycle busy=0, vec=0, no done pulse, pass=0, result bits 0..4 valid; a following start runs a full clean sweep with pass=1.
- start re-asserted mid-sweep → no effect on timing. rst_n pulled low mid-sweep → all outputs 0 immediately. After release, start yields a normal 48-cycle sweep.
